// File: rtl/rv32i_types.sv
// Shared types for the RV32I pipeline control path: controller state and the
// bundle of register-enable / bubble-insert signals it drives.
package rv32i_types;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic load_pc;
    logic load_if_id;
    logic load_id_ex;
    logic load_ex_mem;
    logic load_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
  } ctrl_out_t;

  // Canned output patterns, one per priority level of the controller.
  localparam ctrl_out_t CTRL_RUN      = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam ctrl_out_t CTRL_HOLD     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctrl_out_t CTRL_REDIRECT = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam ctrl_out_t CTRL_BUBBLE   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam ctrl_out_t CTRL_ISTALL   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctrl_out_t CTRL_RESET    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

endpackage

// File: rtl/pipeline_ctrl_perf_counter.sv
// Free-running event counter; wraps naturally at 2^W.
module perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard/stall controller: resolves memory stalls, load-use
// hazards and EX redirects into register enables and bubble inserts.
module pipeline_ctrl
  import rv32i_types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_req,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_redirect,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  ctrl_state_t state_q, state_d;
  logic        squash_q, squash_d;
  ctrl_out_t   ctrl;
  logic        dstall, istall, hazard;
  logic        redirect_hit;

  assign dstall = dmem_req & ~dmem_resp;
  assign istall = imem_req & ~imem_resp;
  assign hazard = ex_mem_read & (ex_rd != 5'd0) &
                  ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    ctrl         = CTRL_RUN;
    state_d      = RUN;
    squash_d     = squash_q;
    redirect_hit = 1'b0;

    if (dstall) begin
      ctrl    = CTRL_HOLD;
      state_d = D_WAIT;
    end else if (ex_redirect) begin
      ctrl         = CTRL_REDIRECT;
      redirect_hit = 1'b1;
      state_d      = istall ? I_WAIT : RUN;
      // A fetch still in flight belongs to the wrong path; remember to drop it.
      if (istall)         squash_d = 1'b1;
      else if (imem_resp) squash_d = 1'b0;
    end else begin
      if (hazard) begin
        ctrl    = CTRL_BUBBLE;
        state_d = istall ? I_WAIT : RUN;
      end else if (istall) begin
        ctrl    = CTRL_ISTALL;
        state_d = I_WAIT;
      end
      // Wrong-path fetch returns: discard it instead of latching it into ID.
      if (squash_q && imem_resp && (state_q != RUN)) begin
        ctrl.flush_if_id = 1'b1;
        squash_d         = 1'b0;
      end
    end

    if (!rst_n) ctrl = CTRL_RESET;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      squash_q <= squash_d;
    end
  end

  assign load_pc     = ctrl.load_pc;
  assign load_if_id  = ctrl.load_if_id;
  assign load_id_ex  = ctrl.load_id_ex;
  assign load_ex_mem = ctrl.load_ex_mem;
  assign load_mem_wb = ctrl.load_mem_wb;
  assign flush_if_id = ctrl.flush_if_id;
  assign flush_id_ex = ctrl.flush_id_ex;

  perf_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (~ctrl.load_pc),
    .cnt_o (stall_cnt)
  );

  perf_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (redirect_hit),
    .cnt_o (redirect_cnt)
  );

endmodule
